// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the nibble-serial borrow-lookahead subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  function automatic int nibbles_for(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/bls4.sv
// Combinational 4-bit borrow-lookahead subtract slice: {bout, d} = a - b - bin.
module bls4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] bb;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Borrows are fully expanded so every bit sees only g/p and bin.
  assign bb[0] = bin;
  assign bb[1] = g[0] | (p[0] & bin);
  assign bb[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign bb[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
  assign bout  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d = a ^ b ^ bb;

endmodule

// File: rtl/serial_bla_subtractor.sv
// Nibble-serial unsigned subtractor (diff = a - b) behind valid/ready handshakes.
// States: IDLE waits for operands, BUSY runs one nibble per cycle, DONE holds the result.
module serial_bla_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int NIBBLES = nibbles_for(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("serial_bla_subtractor: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_q;
  logic             borrow_out_q;
  logic             zero_q;
  logic             out_valid_q;

  logic [IDX_W+1:0] base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       d_nib;
  logic             bout;
  logic             last_nib;

  assign base     = {idx_q, 2'b00};
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    a_nib = a_q[base +: NIBBLE_W];
    b_nib = b_q[base +: NIBBLE_W];
  end

  bls4 u_bls4 (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (borrow_q),
    .d    (d_nib),
    .bout (bout)
  );

  // Merge the current nibble so zero can be judged on the complete result.
  always_comb begin
    diff_d = diff_q;
    diff_d[base +: NIBBLE_W] = d_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          diff_q   <= diff_d;
          borrow_q <= bout;
          idx_q    <= idx_q + IDX_W'(1);
          if (last_nib) begin
            borrow_out_q <= bout;
            zero_q       <= ~|diff_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_bla_subtractor.sv
// Directed and randomised checks of the nibble-serial subtractor and its 4-bit slice.
module tb_serial_bla_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        zero;

  logic [3:0]  s_a;
  logic [3:0]  s_b;
  logic        s_bin;
  logic [3:0]  s_d;
  logic        s_bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_bla_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  bls4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (s_bin),
    .d    (s_d),
    .bout (s_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic [15:0] exp_d, input logic exp_bo, input logic exp_z,
                       input int hold, input bit poke);
    int cyc;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~op_a;
    b = op_a;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      in_valid = poke && (cyc < 2);
      if (poke) check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, 4);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, exp_d);
      check("hold_borrow", borrow_out, exp_bo);
      check("hold_zero", zero, exp_z);
      @(posedge clk); #1;
    end
    check("diff", diff, exp_d);
    check("borrow_out", borrow_out, exp_bo);
    check("zero", zero, exp_z);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int acc[2];
    int k;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [4:0]  slice_exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    s_a       = '0;
    s_b       = '0;
    s_bin     = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 512; i++) begin
      s_a   = i[3:0];
      s_b   = i[7:4];
      s_bin = i[8];
      #1;
      slice_exp = {1'b0, s_a} - {1'b0, s_b} - {4'b0, s_bin};
      check("bls4", {s_bout, s_d}, slice_exp);
    end

    do_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 5, 1'b0);
    do_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1, 1'b1);

    // Back-to-back with in_valid and out_ready held high: 6 - 4 = 2 each time.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 16'h0006;
    b = 16'h0004;
    k = 0;
    acc[0] = -1;
    acc[1] = -1;
    for (int n = 0; n < 16; n++) begin
      if (in_ready && k < 2) begin
        acc[k] = n;
        k++;
      end
      if (out_valid) check("b2b_diff", diff, 16'h0002);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("initiation_interval", acc[1] - acc[0], 6);
    for (int n = 0; n < 20 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("b2b_drained", in_ready, 1);

    // Asynchronous reset in the middle of BUSY.
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_partial", diff, 16'h0003);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    for (int r = 0; r < 1000; r++) begin
      ra = 16'($urandom);
      rb = (r % 10 == 0) ? ra : 16'($urandom);
      do_op(ra, rb, ra - rb, (ra < rb), (ra == rb), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
